// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Writeback scheduler and scoreboard for the 32-entry register file.
// Two writeback sources (s0 = EXU results, s1 = LSU load data) share the
// single register-file write port through a round-robin arbiter. The winning
// request is registered into the write-port stage (rf_*). A per-register busy
// scoreboard records destinations that have an outstanding write. Issue logic
// uses the scoreboard to reserve a destination and to detect read-after-write
// hazards on two source operands.
//
// Ports
//   clk                      clock, all state updates on the rising edge
//   rst                      synchronous active-high reset
//   alloc_valid/alloc_addr   issue-side reservation request
//   alloc_ready              reservation accepted this cycle (combinational)
//   s0_valid/addr/data       EXU writeback request
//   s0_ready                 EXU request granted this cycle (combinational)
//   s1_valid/addr/data       LSU writeback request
//   s1_ready                 LSU request granted this cycle (combinational)
//   rf_wen/rf_waddr/rf_wdata registered register-file write port
//   chk_addr1/chk_addr2      operand addresses to hazard-check
//   chk_busy1/chk_busy2      operand has a pending write (combinational)
//   wb_err                   sticky: a write hit a register that was not reserved
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_addr,
  output logic            alloc_ready,

  input  logic            s0_valid,
  input  logic [AW-1:0]   s0_addr,
  input  logic [XLEN-1:0] s0_data,
  output logic            s0_ready,

  input  logic            s1_valid,
  input  logic [AW-1:0]   s1_addr,
  input  logic [XLEN-1:0] s1_data,
  output logic            s1_ready,

  output logic            rf_wen,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,

  input  logic [AW-1:0]   chk_addr1,
  input  logic [AW-1:0]   chk_addr2,
  output logic            chk_busy1,
  output logic            chk_busy2,

  output logic            wb_err
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NREG-1:0] busy_q, busy_d;
  logic            last_q, last_d;     // source granted most recently
  logic            rf_wen_q, rf_wen_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            wb_err_q, wb_err_d;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------------
  logic [1:0]      grant;
  logic            any_grant;
  logic [AW-1:0]   win_addr;
  logic [XLEN-1:0] win_data;

  always_comb begin
    grant = 2'b00;
    if (s0_valid && s1_valid) begin
      // On a tie the source that did not win last time goes first.
      if (last_q) grant = 2'b01;
      else        grant = 2'b10;
    end else if (s0_valid) begin
      grant = 2'b01;
    end else if (s1_valid) begin
      grant = 2'b10;
    end
  end

  assign any_grant = grant[0] | grant[1];
  assign win_addr  = grant[1] ? s1_addr : s0_addr;
  assign win_data  = grant[1] ? s1_data : s0_data;

  assign s0_ready  = grant[0];
  assign s1_ready  = grant[1];

  always_comb begin
    last_d = last_q;
    if (grant[0]) last_d = 1'b0;
    if (grant[1]) last_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Reservation and hazard checks
  // ---------------------------------------------------------------------------
  logic alloc_fire;

  // x0 is never marked busy, so it is always ready and never reports a hazard.
  assign alloc_ready = ~busy_q[alloc_addr];
  assign alloc_fire  = alloc_valid & alloc_ready;

  assign chk_busy1   = (chk_addr1 != '0) & busy_q[chk_addr1];
  assign chk_busy2   = (chk_addr2 != '0) & busy_q[chk_addr2];

  // ---------------------------------------------------------------------------
  // Scoreboard next state, one bit per architectural register.
  // The commit clear is applied first and a new reservation then sets the bit.
  // A reservation can only hit a register whose bit is currently clear, so the
  // two only meet when an unreserved write commits while the same register is
  // being reserved; the fresh reservation must survive in that case.
  // ---------------------------------------------------------------------------
  logic [NREG-1:0] set_bit;
  logic [NREG-1:0] clr_bit;

  assign set_bit[0] = 1'b0;
  assign clr_bit[0] = 1'b0;
  assign busy_d[0]  = 1'b0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
      assign set_bit[gi] = alloc_fire & (alloc_addr == AW'(gi));
      assign clr_bit[gi] = rf_wen_q   & (rf_waddr_q == AW'(gi));
      assign busy_d[gi]  = set_bit[gi] | (busy_q[gi] & ~clr_bit[gi]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Write-port stage and error flag
  // ---------------------------------------------------------------------------
  logic commit_same;
  logic unreserved_write;

  // A write landing on the register currently being committed is not flagged:
  // its busy bit is in the middle of being released.
  assign commit_same      = rf_wen_q & (rf_waddr_q == win_addr);
  assign unreserved_write = any_grant & (win_addr != '0) &
                            ~busy_q[win_addr] & ~commit_same;

  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (any_grant) begin
      // Writes to x0 are consumed but never reach the register file.
      rf_wen_d   = (win_addr != '0);
      rf_waddr_d = win_addr;
      rf_wdata_d = win_data;
    end
  end

  assign wb_err_d = wb_err_q | unreserved_write;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      last_q     <= 1'b1;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      last_q     <= last_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for rf_wb_arbiter.
// Each record describes the inputs held for one clock cycle and the outputs
// expected during that cycle (combinational outputs for those inputs, and
// registered outputs reflecting earlier edges). Records are applied back to
// back, so the table reads as a cycle-by-cycle trace.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            alloc_valid;
  logic [AW-1:0]   alloc_addr;
  logic            alloc_ready;
  logic            s0_valid;
  logic [AW-1:0]   s0_addr;
  logic [XLEN-1:0] s0_data;
  logic            s0_ready;
  logic            s1_valid;
  logic [AW-1:0]   s1_addr;
  logic [XLEN-1:0] s1_data;
  logic            s1_ready;
  logic            rf_wen;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [AW-1:0]   chk_addr1;
  logic [AW-1:0]   chk_addr2;
  logic            chk_busy1;
  logic            chk_busy2;
  logic            wb_err;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .alloc_ready (alloc_ready),
    .s0_valid    (s0_valid),
    .s0_addr     (s0_addr),
    .s0_data     (s0_data),
    .s0_ready    (s0_ready),
    .s1_valid    (s1_valid),
    .s1_addr     (s1_addr),
    .s1_data     (s1_data),
    .s1_ready    (s1_ready),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .chk_addr1   (chk_addr1),
    .chk_addr2   (chk_addr2),
    .chk_busy1   (chk_busy1),
    .chk_busy2   (chk_busy2),
    .wb_err      (wb_err)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  aa;
    logic        s0v;
    logic [4:0]  s0a;
    logic [31:0] s0d;
    logic        s1v;
    logic [4:0]  s1a;
    logic [31:0] s1d;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic        e_ar;
    logic        e_s0r;
    logic        e_s1r;
    logic        e_cb1;
    logic        e_cb2;
    logic        e_wen;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_err;
  } vec_t;

  localparam logic [31:0] DA = 32'hAAAA_0000;
  localparam logic [31:0] DB = 32'hBBBB_0000;
  localparam logic [31:0] DE = 32'hDEAD_BEEF;
  localparam logic [31:0] D7 = 32'h7777_7777;
  localparam logic [31:0] C1 = 32'hC1C1_C1C1;
  localparam logic [31:0] C2 = 32'hC2C2_C2C2;
  localparam logic [31:0] DZ = 32'h0000_1234;

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    input logic rst_v, input logic av, input logic [4:0] aa,
    input logic s0v, input logic [4:0] s0a, input logic [31:0] s0d,
    input logic s1v, input logic [4:0] s1a, input logic [31:0] s1d,
    input logic [4:0] c1, input logic [4:0] c2,
    input logic e_ar, input logic e_s0r, input logic e_s1r,
    input logic e_cb1, input logic e_cb2,
    input logic e_wen, input logic [4:0] e_wa, input logic [31:0] e_wd,
    input logic e_err);
    vec_t v;
    v.rst = rst_v; v.av = av; v.aa = aa;
    v.s0v = s0v; v.s0a = s0a; v.s0d = s0d;
    v.s1v = s1v; v.s1a = s1a; v.s1d = s1d;
    v.c1 = c1; v.c2 = c2;
    v.e_ar = e_ar; v.e_s0r = e_s0r; v.e_s1r = e_s1r;
    v.e_cb1 = e_cb1; v.e_cb2 = e_cb2;
    v.e_wen = e_wen; v.e_wa = e_wa; v.e_wd = e_wd; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string tag, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s got=%h want=%h", tag, name, act, exp);
    end
  endtask

  // Drive one record for a cycle and compare all outputs mid-cycle.
  task automatic apply(input string tag, input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst;
    alloc_valid = v.av; alloc_addr = v.aa;
    s0_valid = v.s0v; s0_addr = v.s0a; s0_data = v.s0d;
    s1_valid = v.s1v; s1_addr = v.s1a; s1_data = v.s1d;
    chk_addr1 = v.c1; chk_addr2 = v.c2;
    @(negedge clk);
    check(tag, "alloc_ready", 32'(alloc_ready), 32'(v.e_ar));
    check(tag, "s0_ready",    32'(s0_ready),    32'(v.e_s0r));
    check(tag, "s1_ready",    32'(s1_ready),    32'(v.e_s1r));
    check(tag, "chk_busy1",   32'(chk_busy1),   32'(v.e_cb1));
    check(tag, "chk_busy2",   32'(chk_busy2),   32'(v.e_cb2));
    check(tag, "rf_wen",      32'(rf_wen),      32'(v.e_wen));
    check(tag, "rf_waddr",    32'(rf_waddr),    32'(v.e_wa));
    check(tag, "rf_wdata",    rf_wdata,         v.e_wd);
    check(tag, "wb_err",      32'(wb_err),      32'(v.e_err));
    $display("%s rst=%0d alloc=%0d/%0d s0=%0d/%0d s1=%0d/%0d -> rdy=%0d%0d%0d busy=%0d%0d wen=%0d waddr=%0d wdata=%h err=%0d",
             tag, v.rst, v.av, v.aa, v.s0v, v.s0a, v.s1v, v.s1a,
             alloc_ready, s0_ready, s1_ready, chk_busy1, chk_busy2,
             rf_wen, rf_waddr, rf_wdata, wb_err);
  endtask

  vec_t vecs[25];

  initial begin
    // Reset held with all inputs active; x0 targets keep the error flag clean.
    vecs[0]  = mk(1, 1,4, 1,0,DA, 1,0,DB, 4,0,  1,1,0, 0,0, 0,0,0,  0);
    vecs[1]  = mk(1, 1,4, 1,0,DA, 1,0,DB, 4,0,  1,1,0, 0,0, 0,0,0,  0);
    // First cycle after release: s0 wins the tie; x0 write stages data only.
    vecs[2]  = mk(0, 1,4, 1,0,DA, 1,0,DB, 4,0,  1,1,0, 0,0, 0,0,0,  0);
    vecs[3]  = mk(0, 0,0, 0,0,0,  0,0,0,  4,0,  1,0,0, 1,0, 0,0,DA, 0);
    // Reserve x5, then s1 writes it.
    vecs[4]  = mk(0, 1,5, 0,0,0,  0,0,0,  5,4,  1,0,0, 0,1, 0,0,DA, 0);
    vecs[5]  = mk(0, 0,0, 0,0,0,  1,5,DE, 5,0,  1,0,1, 1,0, 0,0,DA, 0);
    vecs[6]  = mk(0, 0,0, 0,0,0,  0,0,0,  5,0,  1,0,0, 1,0, 1,5,DE, 0);
    vecs[7]  = mk(0, 0,0, 0,0,0,  0,0,0,  5,4,  1,0,0, 0,1, 0,5,DE, 0);
    // WAW block on x7 and retry across the commit cycle.
    vecs[8]  = mk(0, 1,7, 0,0,0,  0,0,0,  7,0,  1,0,0, 0,0, 0,5,DE, 0);
    vecs[9]  = mk(0, 1,7, 0,0,0,  0,0,0,  7,0,  0,0,0, 1,0, 0,5,DE, 0);
    vecs[10] = mk(0, 0,0, 1,7,D7, 0,0,0,  7,0,  1,1,0, 1,0, 0,5,DE, 0);
    vecs[11] = mk(0, 1,7, 0,0,0,  0,0,0,  7,0,  0,0,0, 1,0, 1,7,D7, 0);
    vecs[12] = mk(0, 1,7, 0,0,0,  0,0,0,  7,0,  1,0,0, 0,0, 0,7,D7, 0);
    vecs[13] = mk(0, 0,0, 0,0,0,  0,0,0,  7,0,  1,0,0, 1,0, 0,7,D7, 0);
    // x0 handling.
    vecs[14] = mk(0, 1,0, 0,0,0,  0,0,0,  0,7,  1,0,0, 0,1, 0,7,D7, 0);
    vecs[15] = mk(0, 0,0, 0,0,0,  1,0,DZ, 0,7,  1,0,1, 0,1, 0,7,D7, 0);
    vecs[16] = mk(0, 0,0, 0,0,0,  0,0,0,  0,7,  1,0,0, 0,1, 0,0,DZ, 0);
    // Contention on reserved x1/x2; second round hits released registers.
    vecs[17] = mk(0, 1,1, 0,0,0,  0,0,0,  1,2,  1,0,0, 0,0, 0,0,DZ, 0);
    vecs[18] = mk(0, 1,2, 0,0,0,  0,0,0,  1,2,  1,0,0, 1,0, 0,0,DZ, 0);
    vecs[19] = mk(0, 0,0, 1,1,C1, 1,2,C2, 1,2,  1,1,0, 1,1, 0,0,DZ, 0);
    vecs[20] = mk(0, 0,0, 1,1,C1, 1,2,C2, 1,2,  1,0,1, 1,1, 1,1,C1, 0);
    vecs[21] = mk(0, 0,0, 1,1,C1, 1,2,C2, 1,2,  1,1,0, 0,1, 1,2,C2, 0);
    vecs[22] = mk(0, 0,0, 1,1,C1, 1,2,C2, 1,2,  1,0,1, 0,0, 1,1,C1, 1);
    vecs[23] = mk(0, 0,0, 0,0,0,  0,0,0,  1,2,  1,0,0, 0,0, 1,2,C2, 1);
    vecs[24] = mk(0, 0,0, 0,0,0,  0,0,0,  1,2,  1,0,0, 0,0, 0,2,C2, 1);

    rst = 1'b1;
    alloc_valid = 1'b0; alloc_addr = '0;
    s0_valid = 1'b0; s0_addr = '0; s0_data = '0;
    s1_valid = 1'b0; s1_addr = '0; s1_data = '0;
    chk_addr1 = '0; chk_addr2 = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 25; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset clears the sticky error and the x4 reservation.
    apply("rst_mid", mk(1, 0,0, 0,0,0, 0,0,0, 4,0,  1,0,0, 1,0, 0,2,C2, 1));
    // Unreserved write to x9 is still performed and flags an error.
    apply("x9_req",  mk(0, 0,0, 1,9,32'h99, 0,0,0, 4,9,  1,1,0, 0,0, 0,0,0, 0));
    apply("x9_wr",   mk(0, 0,0, 0,0,0, 0,0,0, 9,0,  1,0,0, 0,0, 1,9,32'h99, 1));
    apply("x3_res",  mk(0, 1,3, 0,0,0, 0,0,0, 3,0,  1,0,0, 0,0, 0,9,32'h99, 1));
    apply("x3_gnt",  mk(0, 1,8, 1,3,32'h33, 0,0,0, 3,8,  1,1,0, 1,0, 0,9,32'h99, 1));
    // Reset on the edge after a grant; s1 wins this tie since s0 went last.
    apply("rst_stg", mk(1, 0,0, 1,0,32'h5A5A, 1,0,32'h6B6B, 3,8,  1,0,1, 1,1, 1,3,32'h33, 1));
    // Staged write dropped, reservations gone, s0 wins again after release.
    apply("post_rst", mk(0, 0,0, 1,0,32'h5A5A, 1,0,32'h6B6B, 3,8,  1,1,0, 0,0, 0,0,0, 0));
    apply("post_x0",  mk(0, 0,0, 0,0,0, 0,0,0, 3,8,  1,0,0, 0,0, 0,0,32'h5A5A, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Writeback scheduler and scoreboard for the 32-entry register file in the multicycle core. It shares the single register-file write port between two writeback sources (EXU results and LSU load data) with round-robin arbitration, registers the winning write into the port, and tracks destination registers with outstanding writes. Issue logic uses it to reserve a destination and to stall on read-after-write hazards for both source operands.

## Interface
- `XLEN`, 32, data width of a register-file write
- `NREG`, 32, number of architectural registers; `x0` is hardwired zero
- `AW`, 5, register address width, equal to log2(`NREG`)

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `alloc_valid`  in  1  issue requests reservation of `alloc_addr`
- `alloc_addr`  in  AW  destination register to reserve
- `alloc_ready`  out  1  reservation accepted this cycle (combinational)
- `s0_valid`, `s0_addr`, `s0_data`  in  1/AW/XLEN  EXU writeback request
- `s0_ready`  out  1  EXU request granted this cycle (combinational)
- `s1_valid`, `s1_addr`, `s1_data`  in  1/AW/XLEN  LSU writeback request
- `s1_ready`  out  1  LSU request granted this cycle (combinational)
- `rf_wen`  out  1  register-file write enable (registered)
- `rf_waddr`  out  AW  register-file write address (registered)
- `rf_wdata`  out  XLEN  register-file write data (registered)
- `chk_addr1`, `chk_addr2`  in  AW  operand addresses to check
- `chk_busy1`, `chk_busy2`  out  1  operand has a pending write (combinational)
- `wb_err`  out  1  sticky: a write arrived for a register that was not reserved

## Operation
- State: `busy[NREG-1:0]` scoreboard, `last` 1-bit round-robin pointer, output stage {`rf_wen`, `rf_waddr`, `rf_wdata`}, `wb_err`.
- Reservation: `alloc_ready = !busy[alloc_addr]`. When `alloc_valid && alloc_ready` and `alloc_addr != 0`, set `busy[alloc_addr]`. Reservation of `x0` is always ready and never sets a bit. No WAW reservation is allowed, so each register has at most one outstanding write.
- Arbitration: only one source valid → grant it. Both valid → grant the source that is not `last`. Neither valid → no grant. `sN_ready = grant[N]`. On a grant, `last` becomes N. The output stage never back-pressures, so a valid source waits at most one cycle.
- Output stage loads on a grant: `rf_wen <= (addr != 0)`, `rf_waddr <= addr`, `rf_wdata <= data`. With no grant: `rf_wen <= 0`, and addr/data hold their values.
- Commit: in a cycle with `rf_wen=1`, clear `busy[rf_waddr]` at the end of that cycle. This is the same edge on which the register file captures the data.
- Write to an unreserved register: the write is still performed. `wb_err` sets if the granted `addr != 0` and `busy[addr]=0`, and the destination is not also being committed this cycle. `wb_err` clears only on `rst`.
- Hazard check: `chk_busyK = busy[chk_addrK]`. `chk_addrK=0` always reports 0. There is no bypass.
- Simultaneous events:
  - An alloc to a register whose clear lands on the same edge sees the current busy=1, so `alloc_ready=0`. It succeeds the next cycle.
  - An alloc and a grant in the same cycle to different registers are independent.

## Timing
- Reset values: `busy=0`, `last=1` (so `s0` wins the first tie), `rf_wen=0`, `rf_waddr=0`, `rf_wdata=0`, `wb_err=0`.
- `rst` asserted mid-operation drops any staged write (`rf_wen` is 0 the next cycle) and clears all reservations. Pending source requests are re-arbitrated after `rst` deasserts.
- Latency, with a grant at edge t:
  - `rf_wen=1` during cycle t+1.
  - The register file and `busy` update at the end of t+1.
  - `chk_busy` reads 0 and the register file returns new data from cycle t+2.
- Throughput: one write per cycle. A source held valid under contention is granted every other cycle.
- `alloc_ready`, `sN_ready` and `chk_busyK` are combinational from current state and inputs. They have no dependency on `rf_*` outputs within the same cycle.

## Test plan
- **Reset:** hold `rst` 2 cycles with all inputs active → all outputs 0; `s0_ready=1` and `s1_ready=0` on the first cycle with both valid after release.
- **Reserve then write:** alloc x5 → `chk_busy1(x5)=1`. Present `s1` x5=0xDEADBEEF (one grant) → next cycle `rf_wen=1`, `rf_waddr=5`, `rf_wdata=0xDEADBEEF`. The following cycle `chk_busy1=0`. `wb_err` stays 0.
- **Contention:** `s0` and `s1` valid for 4 cycles, targeting x1 and x2 (both reserved) → grants alternate s0, s1, s0, s1. `rf_waddr` sequence is 1, 2, 1, 2, each one cycle after its grant.
- **WAW block:** alloc x7 twice back-to-back → second `alloc_ready=0`. Write x7 → the alloc retried on the commit cycle still sees 0 and succeeds one cycle later.
- **x0 handling:** alloc x0 → ready, `chk_busy(x0)=0`. Write x0=0x1234 → granted, `rf_wen=0`, no `wb_err`.
- **Error and reset mid-op:** write x9 unreserved → `wb_err=1` and the write is performed. Grant a write, then assert `rst` on the next edge → `rf_wen=0`, `busy=0`, `wb_err=0`.
